// File: rtl/avl_export_pipe.sv
// Registered Avalon-MM export bridge: one-entry command register, fixed-latency read tracking.
// Optional waitrequest watchdog enabled by defining AVL_EXPORT_PIPE_TIMEOUT_EN.
module avl_export_pipe #(
    parameter int pADDR_WIDTH = 8,
    parameter int pDATA_WIDTH = 32,
    parameter int pRD_LATENCY = 1,
    parameter int pTIMEOUT    = 256
) (
    input  logic                   avl_clock,
    input  logic                   avl_rst_n,
    input  logic [pADDR_WIDTH-1:0] s_avl_addr,
    input  logic                   s_avl_wrena,
    input  logic [pDATA_WIDTH-1:0] s_avl_wrdata,
    input  logic                   s_avl_rdena,
    output logic [pDATA_WIDTH-1:0] s_avl_rddata,
    output logic                   s_avl_rdvalid,
    output logic                   s_avl_wrq,
    output logic [pADDR_WIDTH-1:0] m_avl_addr,
    output logic                   m_avl_wrena,
    output logic [pDATA_WIDTH-1:0] m_avl_wrdata,
    output logic                   m_avl_rdena,
    input  logic [pDATA_WIDTH-1:0] m_avl_rddata,
    input  logic                   m_avl_wrq,
    output logic                   timeout_err
);

    if (pRD_LATENCY < 1 || pRD_LATENCY > 8 || pTIMEOUT < 2 || pTIMEOUT > 65535) begin : g_bad_param
        $error("avl_export_pipe: parameter out of range");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state, state_nxt;
    logic                   cmd_load, cmd_done, cmd_abort;
    logic                   tmo_hit, tmo_rd_fire;
    logic [pRD_LATENCY-1:0] trk, trk_nxt;
    logic                   rd_push, rd_emerge;

    always_comb begin
        state_nxt = state;
        cmd_load  = 1'b0;
        cmd_done  = 1'b0;
        cmd_abort = 1'b0;
        case (state)
            IDLE: begin
                if (s_avl_wrena || s_avl_rdena) begin
                    cmd_load  = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!m_avl_wrq) begin
                    cmd_done  = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_hit) begin
                    cmd_abort = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge avl_clock or negedge avl_rst_n) begin
        if (!avl_rst_n) begin
            state        <= IDLE;
            m_avl_addr   <= '0;
            m_avl_wrdata <= '0;
            m_avl_wrena  <= 1'b0;
            m_avl_rdena  <= 1'b0;
            s_avl_wrq    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cmd_load) begin
                // write wins when both strobes arrive together
                m_avl_addr   <= s_avl_addr;
                m_avl_wrdata <= s_avl_wrdata;
                m_avl_wrena  <= s_avl_wrena;
                m_avl_rdena  <= ~s_avl_wrena;
                s_avl_wrq    <= 1'b1;
            end else if (cmd_done || cmd_abort) begin
                m_avl_wrena  <= 1'b0;
                m_avl_rdena  <= 1'b0;
                s_avl_wrq    <= 1'b0;
            end
        end
    end

    assign rd_push   = cmd_done && m_avl_rdena;
    assign rd_emerge = trk[pRD_LATENCY-1];

    always_comb begin
        trk_nxt    = '0;
        trk_nxt[0] = rd_push;
        for (int i = 1; i < pRD_LATENCY; i++) trk_nxt[i] = trk[i-1];
    end

    always_ff @(posedge avl_clock or negedge avl_rst_n) begin
        if (!avl_rst_n) begin
            trk           <= '0;
            s_avl_rddata  <= '0;
            s_avl_rdvalid <= 1'b0;
        end else begin
            trk <= trk_nxt;
            if (rd_emerge) begin
                s_avl_rddata  <= m_avl_rddata;
                s_avl_rdvalid <= 1'b1;
            end else if (tmo_rd_fire) begin
                s_avl_rddata  <= '1;
                s_avl_rdvalid <= 1'b1;
            end else begin
                s_avl_rdvalid <= 1'b0;
            end
        end
    end

`ifdef AVL_EXPORT_PIPE_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        tmo_pend;
    logic        tmo_err_q;

    assign tmo_hit     = (state == BUSY) && m_avl_wrq && (tmo_cnt == 16'(pTIMEOUT - 1));
    assign tmo_rd_fire = (cmd_abort && m_avl_rdena) || tmo_pend;
    assign timeout_err = tmo_err_q;

    // an error return colliding with a tracked return waits one cycle behind it
    always_ff @(posedge avl_clock or negedge avl_rst_n) begin
        if (!avl_rst_n) begin
            tmo_cnt   <= '0;
            tmo_pend  <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            if (cmd_load)
                tmo_cnt <= '0;
            else if (state == BUSY && m_avl_wrq)
                tmo_cnt <= tmo_cnt + 16'd1;
            tmo_pend <= tmo_rd_fire && rd_emerge;
            if (cmd_abort)
                tmo_err_q <= 1'b1;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign tmo_rd_fire = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_avl_export_pipe.sv
// Scoreboard bench for avl_export_pipe with a fixed-latency downstream slave model.
module tb_avl_export_pipe;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int L   = 3;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] s_addr;
    logic          s_wrena, s_rdena;
    logic [DW-1:0] s_wrdata;
    logic [DW-1:0] s_rddata;
    logic          s_rdvalid, s_wrq;
    logic [AW-1:0] m_addr;
    logic          m_wrena, m_rdena;
    logic [DW-1:0] m_wrdata, m_rddata;
    logic          m_wrq;
    logic          tmo_err;

    int total = 0;
    int bad   = 0;
    int wr_done = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    avl_export_pipe #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pRD_LATENCY(L), .pTIMEOUT(TMO)) dut (
        .avl_clock(clk), .avl_rst_n(rst_n),
        .s_avl_addr(s_addr), .s_avl_wrena(s_wrena), .s_avl_wrdata(s_wrdata), .s_avl_rdena(s_rdena),
        .s_avl_rddata(s_rddata), .s_avl_rdvalid(s_rdvalid), .s_avl_wrq(s_wrq),
        .m_avl_addr(m_addr), .m_avl_wrena(m_wrena), .m_avl_wrdata(m_wrdata), .m_avl_rdena(m_rdena),
        .m_avl_rddata(m_rddata), .m_avl_wrq(m_wrq), .timeout_err(tmo_err));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // downstream slave: data for a read accepted at edge K is driven during cycle K+L
    logic [L-1:0]         slv_v;
    logic [L-1:0][DW-1:0] slv_d;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slv_v <= '0;
            slv_d <= '0;
        end else begin
            slv_v <= {slv_v[L-2:0], m_rdena & ~m_wrq};
            slv_d <= {slv_d[L-2:0], {24'hCAFE_00, m_addr}};
        end
    end
    assign m_rddata = slv_v[L-1] ? slv_d[L-1] : 32'hDEAD_BEEF;

    always @(posedge clk) if (rst_n && m_wrena && !m_wrq) wr_done++;

    always @(negedge clk) begin
        if (rst_n && s_rdvalid) begin
            if (exp_q.size() == 0) chk("rd_extra", 1, 0);
            else chk("rdata", s_rddata, exp_q.pop_front());
        end
    end

    task automatic issue(input logic wr, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
        s_wrena = wr; s_rdena = rd; s_addr = a; s_wrdata = d;
        @(negedge clk);
        s_wrena = 0; s_rdena = 0; s_addr = 8'hEE; s_wrdata = 32'h0BAD_0BAD;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wrq"}, s_wrq, 0);
        chk({tag, "_rdv"}, s_rdvalid, 0);
        chk({tag, "_rdd"}, s_rddata, 0);
        chk({tag, "_maddr"}, m_addr, 0);
        chk({tag, "_mwd"}, m_wrdata, 0);
        chk({tag, "_mwr"}, m_wrena, 0);
        chk({tag, "_mrd"}, m_rdena, 0);
        chk({tag, "_terr"}, tmo_err, 0);
    endtask

    initial begin
        int n;
        int w0;
        rst_n = 0; s_wrena = 0; s_rdena = 0; s_addr = 0; s_wrdata = 0; m_wrq = 0;
        #1 chk_zero("rst");
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // single write, no downstream stall
        w0 = wr_done;
        issue(1, 0, 8'h12, 32'hA5A5_0001);
        chk("w_mwr", m_wrena, 1); chk("w_addr", m_addr, 8'h12);
        chk("w_data", m_wrdata, 32'hA5A5_0001); chk("w_swrq", s_wrq, 1);
        @(negedge clk);
        chk("w_mwr_off", m_wrena, 0); chk("w_swrq_off", s_wrq, 0);
        chk("w_addr_hold", m_addr, 8'h12); chk("w_cnt", wr_done - w0, 1);

        // single read, latency measured from the completing edge
        exp_q.push_back(32'hCAFE_0034);
        issue(0, 1, 8'h34, 0);
        chk("r_mrd", m_rdena, 1); chk("r_addr", m_addr, 8'h34);
        n = 0;
        do begin @(negedge clk); n++; end while (!s_rdvalid && n < 20);
        chk("r_lat", n, L + 1);
        @(negedge clk);
        chk("r_pulse", s_rdvalid, 0); chk("r_hold", s_rddata, 32'hCAFE_0034);

        // write held by downstream waitrequest for 5 cycles
        w0 = wr_done;
        m_wrq = 1;
        issue(1, 0, 8'h56, 32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            chk("st_mwr", m_wrena, 1); chk("st_addr", m_addr, 8'h56);
            chk("st_data", m_wrdata, 32'h1234_5678); chk("st_swrq", s_wrq, 1);
            if (i == 4) m_wrq = 0;
            @(negedge clk);
        end
        chk("st_done", m_wrena, 0);
        @(negedge clk);
        chk("st_cnt", wr_done - w0, 1);

        // back-to-back reads at peak rate, then a simultaneous write+read
        for (int i = 0; i < 4; i++) begin
            chk("b2b_ready", s_wrq, 0);
            exp_q.push_back({24'hCAFE_00, 8'(8'h40 + i)});
            issue(0, 1, 8'(8'h40 + i), 0);
            @(negedge clk);
        end
        w0 = wr_done;
        issue(1, 1, 8'h77, 32'hBBBB_0077);
        chk("both_wr", m_wrena, 1); chk("both_rd", m_rdena, 0);
        repeat (12) @(negedge clk);
        chk("both_cnt", wr_done - w0, 1);
        chk("q_empty1", exp_q.size(), 0);

        // read stuck in waitrequest
        m_wrq = 1;
`ifdef AVL_EXPORT_PIPE_TIMEOUT_EN
        exp_q.push_back(32'hFFFF_FFFF);
        s_rdena = 1; s_addr = 8'h99;
        n = 0;
        do begin
            @(negedge clk); n++;
            s_rdena = 0;
        end while (!s_rdvalid && n < 40);
        chk("to_lat", n, TMO + 1);
        chk("to_err", tmo_err, 1); chk("to_mrd", m_rdena, 0); chk("to_swrq", s_wrq, 0);
        m_wrq = 0;
        repeat (5) @(negedge clk);
        chk("to_sticky", tmo_err, 1);
`else
        exp_q.push_back(32'hCAFE_0099);
        issue(0, 1, 8'h99, 0);
        repeat (30) @(negedge clk);
        chk("nt_mrd", m_rdena, 1); chk("nt_swrq", s_wrq, 1); chk("nt_err", tmo_err, 0);
        m_wrq = 0;
        repeat (8) @(negedge clk);
`endif
        chk("q_empty2", exp_q.size(), 0);

        // reset with two reads in flight
        issue(0, 1, 8'hA0, 0);
        @(negedge clk);
        issue(0, 1, 8'hA1, 0);
        @(negedge clk);
        #2 rst_n = 0;
        #1 chk_zero("mid_rst");
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (12) @(negedge clk);
        chk("post_rst_rdv", s_rdvalid, 0);
        chk("q_empty3", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end
endmodule
